adc_cfg_sequencer: RTL
======================

ADC_CFG_SEQUENCER -- requirements
Module: adc_cfg_sequencer

Interface
REQ-001 SHALL have parameter SclkHalf, default 2: CfgClk cycles per SPI SCLK half-period.
REQ-002 SHALL have parameters CfgWord0..CfgWord3, default 16'h0000: setup frames, sent in order.
REQ-003 SHALL have parameters TestPatOn / TestPatOff, default 16'h0000: test-pattern enable/disable frames.
REQ-004 SHALL have parameter ExpPattern, default 16'h3F80: expected per-channel test word.
REQ-005 SHALL have parameters RstCycles (16), Timeout (4096), CheckLen (64), MaxRetry (3), LaneMask (8'h0F).
REQ-006 SHALL have port CfgClk  in  1  sole clock; AdcFrmClk domain.
REQ-007 SHALL have port CfgRst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port Start  in  1  level; sampled only in IDLE.
REQ-009 SHALL have port AdcDataValid  in  8  per-lane alignment-done flags.
REQ-010 SHALL have ports AdcDataCh0 and AdcDataCh1  in  16 each: channel samples.
REQ-011 SHALL have ports SpiSclk, SpiCsn, SpiMosi  out  1 each: ADC SPI master.
REQ-012 SHALL have port IntfRstReq  out  1  LVDS interface reset request.
REQ-013 SHALL have ports Busy, Done, Fail  out  1 each; RetryCnt  out  2.

Function
REQ-014 SHALL implement states IDLE, SPI_XFER, SPI_GAP, INTF_RST, WAIT_ALIGN, CHECK, DONE, FAIL.
REQ-015 SHALL leave IDLE for SPI_XFER when Start=1 and send frames CfgWord0..3, then TestPatOn.
REQ-016 SHALL run SPI in mode 0: SCLK idle low, MSB first, 16 bits per frame, CSN low for the whole frame.
REQ-017 SHALL drive MOSI valid SclkHalf cycles before each SCLK rising edge and change it only while SCLK is low.
REQ-018 SHALL take 32*SclkHalf cycles per frame, then hold CSN high for 2*SclkHalf cycles in SPI_GAP.
REQ-019 SHALL, after TestPatOn, go to INTF_RST and hold IntfRstReq=1 for exactly RstCycles cycles.
REQ-020 SHALL in WAIT_ALIGN count up to Timeout cycles and go to CHECK the first cycle (AdcDataValid & LaneMask) == LaneMask.
REQ-021 SHALL in CHECK require Ch0 == ExpPattern and Ch1 == ExpPattern for CheckLen consecutive cycles.
REQ-022 SHALL treat any miscompare, or loss of any masked valid bit, as a failed attempt; the match counter restarts at 0 on the next attempt.
REQ-023 SHALL treat WAIT_ALIGN reaching Timeout as a failed attempt.
REQ-024 SHALL on a failed attempt increment RetryCnt; if the new value is < MaxRetry, go to INTF_RST; otherwise go to FAIL.
REQ-025 SHALL on a passed CHECK send TestPatOff (SPI_XFER, then SPI_GAP), then enter DONE.
REQ-026 SHALL hold DONE and FAIL until reset; Start is ignored there.
REQ-027 SHALL drive Busy=1 in every state except IDLE, DONE and FAIL.
REQ-028 SHALL drive Done=1 only in DONE and Fail=1 only in FAIL.
REQ-029 SHALL saturate RetryCnt at 3 and hold it through DONE/FAIL.
REQ-030 SHALL drive all outputs from registers (no combinational paths from inputs).

Reset
REQ-031 SHALL on CfgRst=1, immediately and asynchronously: state IDLE, SpiCsn=1, SpiSclk=0, SpiMosi=0, IntfRstReq=0, Busy=0, Done=0, Fail=0, RetryCnt=0, all counters 0.
REQ-032 SHALL, when reset is asserted mid-frame, abort the frame with CSN forced high and retain no partial state.
REQ-033 SHALL leave reset on the first CfgClk edge after CfgRst deasserts.

Verification
REQ-034 SHALL cover SPI framing: CfgWord0=16'hA5C3, SclkHalf=2, Start -> CSN low for 64 cycles, 16 rising SCLK edges, MOSI sampled = A5C3 MSB-first, then CSN high for 4 cycles.
REQ-035 SHALL cover the pass path: all 4 masked valid bits high 10 cycles after IntfRstReq falls, Ch0=Ch1=16'h3F80 for 64 cycles -> TestPatOff frame sent, Done=1, RetryCnt=0.
REQ-036 SHALL cover a single miscompare: Ch1=16'h3F81 at match count 40 on the first attempt, correct data afterwards -> IntfRstReq pulse of 16 cycles, RetryCnt=1, then Done=1.
REQ-037 SHALL cover timeout exhaustion: AdcDataValid held at 0 -> three 4096-cycle timeouts, Fail=1, RetryCnt=3, and no TestPatOff frame.
REQ-038 SHALL cover reset mid-operation: CfgRst asserted at SPI bit 7 -> CSN=1 in the same cycle, all outputs at reset values; Start after release -> transfer restarts from CfgWord0.

Source files
------------

// File: rtl/adc_cfg_sequencer.sv
// adc_cfg_sequencer
// Brings up an LVDS ADC: writes four setup frames and a test-pattern enable
// frame over a mode-0 SPI master, pulses the capture interface reset, waits
// for lane alignment and checks the test pattern for a run of cycles. A bad
// attempt re-runs the interface reset up to MaxRetry attempts in total. On
// success the test pattern is switched off again and Done is raised; on
// exhaustion Fail is raised. Both terminal states hold until reset.
module adc_cfg_sequencer #(
  parameter int          SclkHalf   = 2,
  parameter logic [15:0] CfgWord0   = 16'h0000,
  parameter logic [15:0] CfgWord1   = 16'h0000,
  parameter logic [15:0] CfgWord2   = 16'h0000,
  parameter logic [15:0] CfgWord3   = 16'h0000,
  parameter logic [15:0] TestPatOn  = 16'h0000,
  parameter logic [15:0] TestPatOff = 16'h0000,
  parameter logic [15:0] ExpPattern = 16'h3F80,
  parameter int          RstCycles  = 16,
  parameter int          Timeout    = 4096,
  parameter int          CheckLen   = 64,
  parameter int          MaxRetry   = 3,
  parameter logic [7:0]  LaneMask   = 8'h0F
) (
  input  logic        CfgClk,
  input  logic        CfgRst,
  input  logic        Start,
  input  logic [7:0]  AdcDataValid,
  input  logic [15:0] AdcDataCh0,
  input  logic [15:0] AdcDataCh1,
  output logic        SpiSclk,
  output logic        SpiCsn,
  output logic        SpiMosi,
  output logic        IntfRstReq,
  output logic        Busy,
  output logic        Done,
  output logic        Fail,
  output logic [1:0]  RetryCnt
);

  // CSN-high time between frames
  localparam int GapCycles = 2 * SclkHalf;

  // One shared cycle counter serves the gap, interface reset, alignment
  // timeout and pattern match phases, so it is sized for the longest one.
  localparam int MaxA   = (Timeout > RstCycles) ? Timeout : RstCycles;
  localparam int MaxB   = (CheckLen > GapCycles) ? CheckLen : GapCycles;
  localparam int CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int HalfW  = (SclkHalf > 1) ? $clog2(SclkHalf) : 1;

  // Frame indices: 0..3 setup words, then the two test-pattern frames
  localparam logic [2:0] FrameLastCfg = 3'd3;
  localparam logic [2:0] FramePatOn   = 3'd4;
  localparam logic [2:0] FramePatOff  = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StSpiXfer,
    StSpiGap,
    StIntfRst,
    StWaitAlign,
    StCheck,
    StDone,
    StFail
  } stateT;

  stateT            stateReg, stateNext;
  logic [CntW-1:0]  cntReg, cntNext;
  logic [HalfW-1:0] halfReg, halfNext;
  logic             phaseReg, phaseNext;   // current SCLK level inside a frame
  logic [3:0]       bitReg, bitNext;       // bit position, 0 = MSB
  logic [2:0]       frameReg, frameNext;
  logic [1:0]       retryReg, retryNext;
  logic             attemptFail;

  logic             csnNext;
  logic             sclkNext;
  logic             mosiNext;
  logic             intfRstNext;
  logic             busyNext;
  logic             doneNext;
  logic             failNext;
  logic [15:0]      frameWord;

  logic [7:0]       laneOk;
  logic             aligned;
  logic             dataOk;

  // A lane is satisfied when it is outside the mask or reports alignment
  for (genvar gi = 0; gi < 8; gi++) begin : gLane
    assign laneOk[gi] = !LaneMask[gi] || AdcDataValid[gi];
  end

  assign aligned = &laneOk;
  assign dataOk  = (AdcDataCh0 == ExpPattern) && (AdcDataCh1 == ExpPattern);

  // Retry count is itself a register and can be exported directly
  assign RetryCnt = retryReg;

  // State and counter registers
  always_ff @(posedge CfgClk or posedge CfgRst) begin
    if (CfgRst) begin
      stateReg <= StIdle;
      cntReg   <= '0;
      halfReg  <= '0;
      phaseReg <= 1'b0;
      bitReg   <= '0;
      frameReg <= '0;
      retryReg <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      halfReg  <= halfNext;
      phaseReg <= phaseNext;
      bitReg   <= bitNext;
      frameReg <= frameNext;
      retryReg <= retryNext;
    end
  end

  // Next-state and counter logic
  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    halfNext    = halfReg;
    phaseNext   = phaseReg;
    bitNext     = bitReg;
    frameNext   = frameReg;
    retryNext   = retryReg;
    attemptFail = 1'b0;

    case (stateReg)
      StIdle: begin
        if (Start) begin
          stateNext = StSpiXfer;
          frameNext = '0;
          halfNext  = '0;
          phaseNext = 1'b0;
          bitNext   = '0;
        end
      end

      StSpiXfer: begin
        // Each bit is SclkHalf cycles low followed by SclkHalf cycles high
        if (halfReg == HalfW'(SclkHalf - 1)) begin
          halfNext  = '0;
          phaseNext = ~phaseReg;
          if (phaseReg) begin
            if (bitReg == 4'd15) begin
              stateNext = StSpiGap;
              cntNext   = '0;
              bitNext   = '0;
            end else begin
              bitNext = bitReg + 4'd1;
            end
          end
        end else begin
          halfNext = halfReg + HalfW'(1);
        end
      end

      StSpiGap: begin
        if (cntReg == CntW'(GapCycles - 1)) begin
          cntNext = '0;
          if (frameReg == FramePatOff) begin
            stateNext = StDone;
          end else if (frameReg == FramePatOn) begin
            stateNext = StIntfRst;
          end else begin
            // Setup words run straight into the test-pattern enable frame
            frameNext = (frameReg == FrameLastCfg) ? FramePatOn : frameReg + 3'd1;
            stateNext = StSpiXfer;
          end
        end else begin
          cntNext = cntReg + CntW'(1);
        end
      end

      StIntfRst: begin
        if (cntReg == CntW'(RstCycles - 1)) begin
          stateNext = StWaitAlign;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + CntW'(1);
        end
      end

      StWaitAlign: begin
        if (aligned) begin
          stateNext = StCheck;
          cntNext   = '0;
        end else if (cntReg == CntW'(Timeout - 1)) begin
          attemptFail = 1'b1;
        end else begin
          cntNext = cntReg + CntW'(1);
        end
      end

      StCheck: begin
        // Losing alignment counts the same as a wrong sample
        if (!aligned || !dataOk) begin
          attemptFail = 1'b1;
        end else if (cntReg == CntW'(CheckLen - 1)) begin
          stateNext = StSpiXfer;
          frameNext = FramePatOff;
          cntNext   = '0;
          halfNext  = '0;
          phaseNext = 1'b0;
          bitNext   = '0;
        end else begin
          cntNext = cntReg + CntW'(1);
        end
      end

      StDone: stateNext = StDone;

      StFail: stateNext = StFail;

      default: stateNext = StIdle;
    endcase

    // Shared failed-attempt handling for timeout and pattern miscompare
    if (attemptFail) begin
      retryNext = (retryReg == 2'd3) ? 2'd3 : retryReg + 2'd1;
      cntNext   = '0;
      if (int'(retryNext) < MaxRetry) begin
        stateNext = StIntfRst;
      end else begin
        stateNext = StFail;
      end
    end
  end

  // Frame word for the frame about to be on the wire
  always_comb begin
    case (frameNext)
      3'd0:    frameWord = CfgWord0;
      3'd1:    frameWord = CfgWord1;
      3'd2:    frameWord = CfgWord2;
      3'd3:    frameWord = CfgWord3;
      3'd4:    frameWord = TestPatOn;
      3'd5:    frameWord = TestPatOff;
      default: frameWord = 16'h0000;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe
  always_comb begin
    csnNext     = 1'b1;
    sclkNext    = 1'b0;
    mosiNext    = 1'b0;
    intfRstNext = 1'b0;
    busyNext    = 1'b1;
    doneNext    = 1'b0;
    failNext    = 1'b0;

    case (stateNext)
      StSpiXfer: begin
        csnNext  = 1'b0;
        sclkNext = phaseNext;
        // MOSI only moves at bit boundaries, which coincide with SCLK low
        mosiNext = frameWord[4'd15 - bitNext];
      end
      StIntfRst: intfRstNext = 1'b1;
      StIdle:    busyNext = 1'b0;
      StDone: begin
        busyNext = 1'b0;
        doneNext = 1'b1;
      end
      StFail: begin
        busyNext = 1'b0;
        failNext = 1'b1;
      end
      default: busyNext = 1'b1;
    endcase
  end

  // Output registers; reset forces CSN high to abort any frame in flight
  always_ff @(posedge CfgClk or posedge CfgRst) begin
    if (CfgRst) begin
      SpiCsn     <= 1'b1;
      SpiSclk    <= 1'b0;
      SpiMosi    <= 1'b0;
      IntfRstReq <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Fail       <= 1'b0;
    end else begin
      SpiCsn     <= csnNext;
      SpiSclk    <= sclkNext;
      SpiMosi    <= mosiNext;
      IntfRstReq <= intfRstNext;
      Busy       <= busyNext;
      Done       <= doneNext;
      Fail       <= failNext;
    end
  end

endmodule
